// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  // Operand forwarding mux selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Shadow tag for an in-flight instruction in EX or MEM.
  typedef struct packed {
    logic                 vld;
    logic [REG_IDX_W-1:0] rd;
    logic                 wen;
    logic                 is_load;
  } tag_t;

  localparam int HZ_TAG_LEN = $bits(tag_t);

  // A tag produces a register result only if it is live, writes, and does not target x0.
  function automatic logic tag_writing(input tag_t t);
    return t.vld & t.wen & (t.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_occ_cnt.sv
// Loadable down-counter tracking how many more cycles a mul/div holds EX.
// Latency: busy asserts the cycle after load; stays high MD_LAT-1 cycles.
// Backpressure: none; load is ignored while already counting.
module md_occ_cnt #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = $clog2(MD_LAT+1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_vld,
  output logic busy_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count down while busy; otherwise arm with the remaining occupancy on load.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (load_vld) begin
      cnt_d = CNT_W'(MD_LAT - 1);
    end
  end

  // Counter register; reset aborts any count in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock/forwarding scheduler: shadow EX/MEM dest tags drive stalls, bubbles, flushes, fwd selects.
// Latency: all outputs combinational from registered tags/counter and current ID inputs.
// Backpressure: stalls IF/ID on load-use or mul/div occupancy; redirect flushes and wins over load-use.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = $clog2(MD_LAT+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs1_idx_i,
  input  logic [REG_IDX_W-1:0] id_rs2_idx_i,
  input  logic                 id_rs1_used_i,
  input  logic                 id_rs2_used_i,
  input  logic [REG_IDX_W-1:0] id_rd_idx_i,
  input  logic                 id_rd_wen_i,
  input  logic                 id_is_load_i,
  input  logic                 id_is_md_i,
  input  logic                 ex_redirect_i,
  output logic                 if_stall_o,
  output logic                 id_stall_o,
  output logic                 id_flush_o,
  output logic                 ex_bubble_o,
  output logic [1:0]           rs1_fwd_sel_o,
  output logic [1:0]           rs2_fwd_sel_o,
  output logic                 md_busy_o
);

  tag_t ex_tag_q, ex_tag_d;
  tag_t mem_tag_q, mem_tag_d;
  tag_t id_tag;

  logic md_busy;
  logic md_load;
  logic load_use;
  logic stall;
  logic issue;

  // Youngest producer wins; a load or an unfinished mul/div in EX has no value to forward yet.
  function automatic logic [1:0] pick_fwd(input logic used, input logic [REG_IDX_W-1:0] idx,
                                          input tag_t ex_t, input tag_t mem_t, input logic busy);
    logic [1:0] sel;
    sel = FWD_RF;
    if (used) begin
      if (tag_writing(ex_t) && (ex_t.rd == idx) && !ex_t.is_load && !busy) begin
        sel = FWD_EX;
      end else if (tag_writing(mem_t) && (mem_t.rd == idx)) begin
        sel = FWD_MEM;
      end
    end
    return sel;
  endfunction

  md_occ_cnt #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md_occ_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_vld (md_load),
    .busy_o   (md_busy)
  );

  assign id_tag = '{vld: 1'b1, rd: id_rd_idx_i, wen: id_rd_wen_i, is_load: id_is_load_i};

  // Hazard detection and stall/flush priority; redirect overrides any stall.
  always_comb begin
    load_use = tag_writing(ex_tag_q) & ex_tag_q.is_load &
               ((id_rs1_used_i & (ex_tag_q.rd == id_rs1_idx_i)) |
                (id_rs2_used_i & (ex_tag_q.rd == id_rs2_idx_i)));
    stall         = (load_use | md_busy) & ~ex_redirect_i;
    if_stall_o    = stall;
    id_stall_o    = stall;
    id_flush_o    = ex_redirect_i;
    ex_bubble_o   = ex_redirect_i | load_use;
    issue         = id_valid_i & ~stall & ~ex_redirect_i;
    md_load       = issue & id_is_md_i;
    md_busy_o     = md_busy;
    rs1_fwd_sel_o = pick_fwd(id_rs1_used_i, id_rs1_idx_i, ex_tag_q, mem_tag_q, md_busy);
    rs2_fwd_sel_o = pick_fwd(id_rs2_used_i, id_rs2_idx_i, ex_tag_q, mem_tag_q, md_busy);
  end

  // Tag pipeline advance: hold EX and drain MEM while a mul/div occupies EX.
  always_comb begin
    ex_tag_d  = ex_tag_q;
    mem_tag_d = '0;
    if (!md_busy) begin
      mem_tag_d = ex_tag_q;
      ex_tag_d  = issue ? id_tag : '0;
    end
  end

  // Shadow tag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_tag_q  <= '0;
      mem_tag_q <= '0;
    end else begin
      ex_tag_q  <= ex_tag_d;
      mem_tag_q <= mem_tag_d;
    end
  end

endmodule
